exe_mul_unit: RTL and testbench
===============================

Name: exe_mul_unit

Overview:
- Iterative multiply / multiply-accumulate unit for ARM MUL/MLA in the execute stage.
- Sits directly upstream of the status register: produces the 32-bit result and the next NZCV value, plus a one-cycle update strobe that drives the status register's update enable.
- Stalls the pipeline while it iterates, one multiplier bit per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- i_Start  input  1  request; sampled only in IDLE.
- i_Accumulate  input  1  1 = MLA (add i_Rn), 0 = MUL; latched with i_Start.
- i_S  input  1  S-bit; latched with i_Start.
- i_Rm  input  WIDTH  multiplier; latched with i_Start.
- i_Rs  input  WIDTH  multiplicand; latched with i_Start.
- i_Rn  input  WIDTH  accumulate operand; latched with i_Start.
- i_Status  input  4  current flags {N,Z,C,V}; latched with i_Start.
- i_Flush  input  1  synchronous abort.
- o_Busy  output  1  high in MULT and ACC; used as a pipeline stall.
- o_Done  output  1  one-cycle completion pulse.
- o_Result  output  WIDTH  low WIDTH bits of the product or the sum.
- o_Status  output  4  next flags {N,Z,C,V}.
- o_Status_Update  output  1  equals o_Done AND latched S; feeds the status-register update enable.

Behaviour:
- Reset (async): state IDLE. o_Busy, o_Done, o_Status_Update, o_Result, o_Status and all internal registers are 0.
- States: IDLE, MULT, ACC, DONE.
- IDLE:
  - On i_Start=1 and i_Flush=0: latch all operands, clear the accumulator and counter, then go to MULT.
  - Otherwise stay in IDLE.
- MULT:
  - Each cycle: if multiplier LSB = 1, acc += multiplicand (modulo 2^WIDTH).
  - Then multiplicand <<= 1, multiplier >>= 1, counter += 1.
  - After WIDTH iterations: go to ACC if i_Accumulate was latched, else DONE.
- ACC: acc = acc + Rn (modulo 2^WIDTH, carry-out discarded); one cycle, then DONE.
- DONE:
  - o_Done = 1 for exactly one cycle; o_Status_Update = latched S.
  - o_Result = acc; it holds until the next DONE.
  - o_Status: N = acc[WIDTH-1]; Z = (acc == 0); C and V are copied from the latched i_Status (MUL/MLA preserve C and V).
  - o_Status holds its value outside DONE.
  - Next state is IDLE.
- Latency:
  - MUL: o_Done is high in cycle WIDTH+1 after the start edge (edge 0 = start sampled).
  - MLA: cycle WIDTH+2.
  - o_Busy is high from cycle 1 up to, but not including, the DONE cycle.
- i_Start while not IDLE: ignored; no queuing.
- i_Flush:
  - In MULT or ACC: next state IDLE; no o_Done and no o_Status_Update; o_Result and o_Status keep their previous values.
  - In DONE: the pulse still completes (the result is already committed).
  - In IDLE: blocks the start.
- i_Flush and i_Start together in IDLE: flush wins; stay IDLE.
- Reset mid-operation: returns immediately to the reset values; no pulse is emitted.
- Back-to-back operations: the earliest next start is the IDLE cycle following DONE.

Optional Feature:
- Macro MUL_EARLY_TERMINATE_EN.
- Defined: MULT exits as soon as the shifted multiplier is 0 after an iteration. Minimum is 1 iteration; i_Rm = 0 gives 1 iteration. Iteration count = max(1, index of highest set bit of i_Rm + 1). Results and flags are identical to the non-early build.
- Undefined: always WIDTH iterations, giving fixed latency.

Test Plan:
- MUL 7×6, S=1, i_Status=4'b0011 -> o_Done in cycle 33; o_Result=0x0000002A; o_Status=4'b0011; o_Status_Update=1.
- MLA Rm=3, Rs=5, Rn=0xFFFFFFF1, S=1, i_Status=4'b1000 -> o_Done in cycle 34; o_Result=0x00000000; o_Status=4'b0100 (Z=1, N=0, C=V=0 preserved).
- MUL 0xFFFFFFFF×1, S=0 -> o_Result=0xFFFFFFFF; o_Status=4'b1000 (N=1); o_Status_Update=0 while o_Done=1.
- Start MUL; pulse i_Start again at cycle 5; assert i_Flush at cycle 10 -> back to IDLE in cycle 11; no o_Done; o_Result unchanged; o_Busy=0.
- Start MUL 2×3; assert reset at cycle 15 -> all outputs 0 immediately; a new MUL 2×3 after release gives o_Result=6.
- With MUL_EARLY_TERMINATE_EN: MUL Rm=5, Rs=9 -> o_Done in cycle 4; o_Result=45. Rm=0 -> o_Done in cycle 2; o_Result=0; Z=1.

Source files
------------

// File: rtl/exe_mul_unit.sv
// Iterative shift-and-add MUL/MLA unit for the execute stage, one multiplier bit per cycle.
// Optional build macro MUL_EARLY_TERMINATE_EN stops iterating once the remaining multiplier is zero.
module exe_mul_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_Start,
    input  logic             i_Accumulate,
    input  logic             i_S,
    input  logic [WIDTH-1:0] i_Rm,
    input  logic [WIDTH-1:0] i_Rs,
    input  logic [WIDTH-1:0] i_Rn,
    input  logic [3:0]       i_Status,
    input  logic             i_Flush,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [WIDTH-1:0] o_Result,
    output logic [3:0]       o_Status,
    output logic             o_Status_Update
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt_w
        $error("exe_mul_unit: CNT_W too small to count WIDTH iterations");
    end

    // Handshake: i_Start is a one-cycle request honoured only in IDLE; there is no
    // ready signal, the caller holds the pipeline while o_Busy is high and takes the
    // result in the single cycle o_Done is high.
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rn_q;
    logic [CNT_W-1:0] cnt;
    logic             accum_q;
    logic             s_q;
    logic [3:0]       st_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       status_q;

    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mplier_shift;
    logic             last_iter;
    logic             start_ok;
    logic [3:0]       done_status;

    assign start_ok     = i_Start && !i_Flush;
    assign acc_step     = mplier[0] ? (acc + mcand) : acc;
    assign mplier_shift = mplier >> 1;

`ifdef MUL_EARLY_TERMINATE_EN
    assign last_iter = (cnt == LAST_CNT) || (mplier_shift == '0);
`else
    assign last_iter = (cnt == LAST_CNT);
`endif

    // N and Z come from the result; C and V pass through from the latched flags.
    assign done_status = (st_q & 4'b0011) | {acc[WIDTH-1], (acc == '0), 2'b00};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_MULT;
                end
            end
            S_MULT: begin
                if (i_Flush) begin
                    state_nxt = S_IDLE;
                end else if (last_iter) begin
                    state_nxt = accum_q ? S_ACC : S_DONE;
                end
            end
            S_ACC: begin
                state_nxt = i_Flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mplier   <= '0;
            mcand    <= '0;
            acc      <= '0;
            rn_q     <= '0;
            cnt      <= '0;
            accum_q  <= 1'b0;
            s_q      <= 1'b0;
            st_q     <= 4'b0000;
            result_q <= '0;
            status_q <= 4'b0000;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        mplier  <= i_Rm;
                        mcand   <= i_Rs;
                        rn_q    <= i_Rn;
                        accum_q <= i_Accumulate;
                        s_q     <= i_S;
                        st_q    <= i_Status;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                S_MULT: begin
                    if (!i_Flush) begin
                        acc    <= acc_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier_shift;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                S_ACC: begin
                    if (!i_Flush) begin
                        acc <= acc + rn_q;
                    end
                end
                S_DONE: begin
                    // Commit regardless of i_Flush: the result is already architectural.
                    result_q <= acc;
                    status_q <= done_status;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_Busy          = (state == S_MULT) || (state == S_ACC);
    assign o_Done          = (state == S_DONE);
    assign o_Status_Update = o_Done && s_q;
    assign o_Result        = o_Done ? acc : result_q;
    assign o_Status        = o_Done ? done_status : status_q;

endmodule

// File: tb/tb_exe_mul_unit.sv
// Bench for exe_mul_unit: directed vector table, random ops against an arithmetic model,
// and hand-written flush / reset sequences.
module tb_exe_mul_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_Start, i_Accumulate, i_S, i_Flush;
    logic [W-1:0]  i_Rm, i_Rs, i_Rn;
    logic [3:0]    i_Status;
    logic          o_Busy, o_Done, o_Status_Update;
    logic [W-1:0]  o_Result;
    logic [3:0]    o_Status;

    int n_vec = 0;
    int n_err = 0;

    exe_mul_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .i_Start(i_Start), .i_Accumulate(i_Accumulate), .i_S(i_S),
        .i_Rm(i_Rm), .i_Rs(i_Rs), .i_Rn(i_Rn), .i_Status(i_Status),
        .i_Flush(i_Flush),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Result(o_Result),
        .o_Status(o_Status), .o_Status_Update(o_Status_Update)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rm, rs, rn;
        logic         acc, s;
        logic [3:0]   st;
        logic [W-1:0] exp_res;
        logic [3:0]   exp_st;
        logic         exp_upd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected cycle of o_Done after the start edge.
    function automatic int lat_model(input logic [W-1:0] rm, input logic acc);
        int iters;
        iters = W;
`ifdef MUL_EARLY_TERMINATE_EN
        iters = 1;
        for (int i = 0; i < W; i++) if (rm[i]) iters = i + 1;
`endif
        return iters + 1 + (acc ? 1 : 0);
    endfunction

    function automatic logic [W-1:0] res_model(input logic [W-1:0] rm, rs, rn, input logic acc);
        longint unsigned p;
        p = longint'(rm) * longint'(rs) + (acc ? longint'(rn) : 64'd0);
        return p[W-1:0];
    endfunction

    function automatic logic [3:0] st_model(input logic [W-1:0] r, input logic [3:0] st);
        return {r[W-1], (r == 0), st[1], st[0]};
    endfunction

    // Starts one operation and waits for o_Done; operand inputs are scrambled after the
    // start edge so only latched values can produce the right answer.
    task automatic run_op(input logic [W-1:0] rm, rs, rn, input logic acc, s, input logic [3:0] st,
                          output logic [W-1:0] res, output logic [3:0] sto, output logic upd,
                          output int lat, output logic busy_bad);
        @(negedge clk);
        i_Rm = rm; i_Rs = rs; i_Rn = rn; i_Accumulate = acc; i_S = s; i_Status = st;
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        i_Rm = $urandom; i_Rs = $urandom; i_Rn = $urandom;
        i_Accumulate = ~acc; i_S = ~s; i_Status = ~st;
        lat = 1;
        busy_bad = 1'b0;
        while (!o_Done && lat < 100) begin
            if (!o_Busy) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (o_Busy) busy_bad = 1'b1;
        res = o_Result; sto = o_Status; upd = o_Status_Update;
    endtask

    logic [W-1:0] res, exp_res, rm, rs, rn;
    logic [3:0]   sto, exp_st, st;
    logic         upd, busy_bad, acc, s, done_seen;
    int           lat;

    initial begin
        vecs[0] = '{32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'b0011, 32'h0000002A, 4'b0011, 1'b1};
        vecs[1] = '{32'd3, 32'd5, 32'hFFFFFFF1, 1'b1, 1'b1, 4'b1000, 32'h00000000, 4'b0100, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 4'b0000, 32'hFFFFFFFF, 4'b1000, 1'b0};
        vecs[3] = '{32'd0, 32'h12345678, 32'd0, 1'b0, 1'b1, 4'b1111, 32'h00000000, 4'b0111, 1'b1};
        vecs[4] = '{32'h80000000, 32'd2, 32'd0, 1'b0, 1'b1, 4'b0010, 32'h00000000, 4'b0110, 1'b1};
        vecs[5] = '{32'h0000FFFF, 32'h0000FFFF, 32'd1, 1'b1, 1'b1, 4'b0001, 32'hFFFE0002, 4'b1001, 1'b1};
        vecs[6] = '{32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 4'b0000, 32'd6, 4'b0000, 1'b1};

        reset = 1'b1;
        i_Start = 1'b0; i_Accumulate = 1'b0; i_S = 1'b0; i_Flush = 1'b0;
        i_Rm = '0; i_Rs = '0; i_Rn = '0; i_Status = 4'b0000;
        repeat (2) @(negedge clk);
        chk("reset_busy", o_Busy, 0);
        chk("reset_done", o_Done, 0);
        chk("reset_upd", o_Status_Update, 0);
        chk("reset_result", o_Result, 0);
        chk("reset_status", o_Status, 0);
        reset = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].rm, vecs[i].rs, vecs[i].rn, vecs[i].acc, vecs[i].s, vecs[i].st,
                   res, sto, upd, lat, busy_bad);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_status", i), sto, vecs[i].exp_st);
            chk($sformatf("vec%0d_update", i), upd, vecs[i].exp_upd);
            chk($sformatf("vec%0d_latency", i), lat, lat_model(vecs[i].rm, vecs[i].acc));
            chk($sformatf("vec%0d_busy", i), busy_bad, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), o_Done, 0);
            chk($sformatf("vec%0d_hold_result", i), o_Result, vecs[i].exp_res);
            chk($sformatf("vec%0d_hold_status", i), o_Status, vecs[i].exp_st);
        end

        // Random operations against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            rm = $urandom;
            if ($urandom_range(0, 1) == 1) rm = rm >> $urandom_range(0, 31);
            rs = $urandom; rn = $urandom;
            acc = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            st = 4'($urandom_range(0, 15));
            exp_res = res_model(rm, rs, rn, acc);
            exp_st = st_model(exp_res, st);
            run_op(rm, rs, rn, acc, s, st, res, sto, upd, lat, busy_bad);
            chk($sformatf("rnd%0d_result", i), res, exp_res);
            chk($sformatf("rnd%0d_status", i), sto, exp_st);
            chk($sformatf("rnd%0d_update", i), upd, s);
            chk($sformatf("rnd%0d_latency", i), lat, lat_model(rm, acc));
            chk($sformatf("rnd%0d_busy", i), busy_bad, 0);
        end

        // Last committed values, which the aborts below must leave untouched.
        @(negedge clk);
        exp_res = o_Result; exp_st = o_Status;

        // Flush mid-MULT, with a stray start in between.
        i_Rm = 32'd7; i_Rs = 32'd6; i_Accumulate = 1'b0; i_S = 1'b1; i_Status = 4'b0000;
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        done_seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (o_Done) done_seen = 1'b1;
            if (c == 5) i_Start = 1'b1;
            if (c == 6) i_Start = 1'b0;
            if (c == 10) i_Flush = 1'b1;
            @(negedge clk);
        end
        i_Flush = 1'b0;
        chk("flush_busy", o_Busy, 0);
        chk("flush_done", o_Done, 0);
        chk("flush_result", o_Result, exp_res);
        chk("flush_status", o_Status, exp_st);
        for (int c = 0; c < 40; c++) begin
            if (o_Done || o_Status_Update || o_Busy) done_seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_pulse", done_seen, 0);

        // Flush and start together in IDLE: flush wins.
        i_Start = 1'b1; i_Flush = 1'b1;
        @(negedge clk);
        i_Start = 1'b0; i_Flush = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (o_Done || o_Busy) done_seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_start_idle", done_seen, 0);

        // Flush during DONE does not cancel the commit.
        i_Rm = 32'd9; i_Rs = 32'd11; i_Rn = 32'd4; i_Accumulate = 1'b1; i_S = 1'b1; i_Status = 4'b0010;
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        lat = 1;
        while (!o_Done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("flushdone_latency", lat, lat_model(32'd9, 1'b1));
        chk("flushdone_update", o_Status_Update, 1);
        i_Flush = 1'b1;
        @(negedge clk);
        i_Flush = 1'b0;
        chk("flushdone_result", o_Result, 32'd103);
        chk("flushdone_status", o_Status, 4'b0010);

        // Asynchronous reset mid-operation.
        i_Rm = 32'd2; i_Rs = 32'd3; i_Accumulate = 1'b0; i_S = 1'b1; i_Status = 4'b1111;
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_busy", o_Busy, 0);
        chk("midreset_done", o_Done, 0);
        chk("midreset_upd", o_Status_Update, 0);
        chk("midreset_result", o_Result, 0);
        chk("midreset_status", o_Status, 0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 4'b0000, res, sto, upd, lat, busy_bad);
        chk("after_reset_result", res, 32'd6);
        chk("after_reset_latency", lat, lat_model(32'd2, 1'b0));

`ifdef MUL_EARLY_TERMINATE_EN
        run_op(32'd5, 32'd9, 32'd0, 1'b0, 1'b1, 4'b0000, res, sto, upd, lat, busy_bad);
        chk("early_5x9_result", res, 32'd45);
        chk("early_5x9_latency", lat, 4);
        run_op(32'd0, 32'd9, 32'd0, 1'b0, 1'b1, 4'b0000, res, sto, upd, lat, busy_bad);
        chk("early_zero_result", res, 32'd0);
        chk("early_zero_latency", lat, 2);
        chk("early_zero_status", sto, 4'b0100);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
